// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size encodings,
// FSM state type and the alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and the
// read-modify-write merge for sub-word stores.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        isSigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [31:0] byteShift;
  logic [31:0] halfShift;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteShift = word >> {offset, 3'b000};
    halfShift = word >> {offset[1], 4'b0000};
    byteSel   = byteShift[7:0];
    halfSel   = halfShift[15:0];

    case (size)
      SZ_BYTE: loadData = {{24{isSigned & byteSel[7]}}, byteSel};
      SZ_HALF: loadData = {{16{isSigned & halfSel[15]}}, halfSel};
      default: loadData = word;
    endcase

    mergeData = word;
    case (size)
      SZ_BYTE: mergeData[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: mergeData[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: mergeData = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one access at a time, sub-word stores done
// as read-modify-write, loads returned aligned and extended.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        debugState
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse.

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              signedQ;
  logic              writeQ;
  logic [31:0]       wdataQ;
  logic              errQ;
  logic [31:0]       wordQ;
  logic [31:0]       lastWdataQ;
  logic              accept;
  logic              reqBad;
  logic [31:0]       loadData;
  logic [31:0]       mergeData;

  assign accept = req_valid && (state == IDLE);
  assign reqBad = (req_size == 2'b11) || is_misaligned(req_size, req_addr[1:0]);

  lane_align uAlign (
    .size      (sizeQ),
    .offset    (addrQ[1:0]),
    .isSigned  (signedQ),
    .word      (wordQ),
    .wdata     (wdataQ),
    .loadData  (loadData),
    .mergeData (mergeData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      sizeQ      <= '0;
      signedQ    <= 1'b0;
      writeQ     <= 1'b0;
      wdataQ     <= '0;
      errQ       <= 1'b0;
      wordQ      <= '0;
      lastWdataQ <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        addrQ   <= req_addr;
        sizeQ   <= req_size;
        signedQ <= req_signed;
        writeQ  <= req_write;
        wdataQ  <= req_wdata;
        errQ    <= reqBad;
      end
      if (state == READ) wordQ <= mem_rdata[31:0];
      if (state == WRITE) lastWdataQ <= mergeData;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reqBad) stateNext = RESP;
          else if (!req_write || (req_size != SZ_WORD)) stateNext = READ;
          else stateNext = WRITE;
        end
      end
      READ:    stateNext = writeQ ? WRITE : RESP;
      WRITE:   stateNext = RESP;
      default: stateNext = IDLE;
    endcase
  end

  // Every output decodes from state or captured registers, never from request inputs.
  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    resp_err       = (state == RESP) && errQ;
    resp_rdata     = ((state == RESP) && !errQ && !writeQ) ? loadData : 32'h0;
    mem_we         = (state == WRITE);
    mem_wdata      = (state == WRITE) ? mergeData : lastWdataQ;
    mem_read_addr  = addrQ >> 2;
    mem_write_addr = addrQ >> 2;
    debugState     = state;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  debug_state;

  logic [31:0] mem [0:15];
  logic [32:0] exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we_lat;
    logic [31:0] exp_we_idx;
    logic [31:0] exp_we_data;
  } vec_t;

  vec_t vecs [0:15];

  mem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_addr  (mem_read_addr),
    .mem_rdata      (mem_rdata),
    .mem_write_addr (mem_write_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .debugState     (debug_state)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_read_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_write_addr[3:0]] <= mem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_err, input logic [31:0] exp_rdata,
                              input int exp_lat, input int exp_we_lat,
                              input logic [31:0] exp_we_idx, input logic [31:0] exp_we_data);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    v.exp_we_lat = exp_we_lat; v.exp_we_idx = exp_we_idx; v.exp_we_data = exp_we_data;
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return sgn && b[7] ? {24'hFFFFFF, b} : {24'h0, b};
    if (sz == 2'b01) return sgn && h[15] ? {16'hFFFF, h} : {16'h0, h};
    return w;
  endfunction

  // driver: issue one request, observe we/resp per cycle, score against expectation
  task automatic run_req(input vec_t v, input string tag);
    int          we_lat;
    int          resp_lat;
    logic [31:0] we_idx;
    logic [31:0] we_data;
    logic [32:0] got;
    logic [32:0] exp;
    we_lat = 0; resp_lat = 0; we_idx = 0; we_data = 0; got = 0;
    @(negedge clk);
    check({tag, " ready"}, {32'h0, req_ready}, 33'd1);
    req_write = v.wr; req_size = v.sz; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin
        if (we_lat == 0) begin
          we_lat = k; we_idx = mem_write_addr; we_data = mem_wdata;
        end else begin
          we_lat = 99;
        end
      end
      if (resp_valid) begin
        resp_lat = k;
        got = {resp_err, resp_rdata};
        break;
      end
      @(negedge clk);
    end
    check({tag, " resp latency"}, 33'(resp_lat), 33'(v.exp_lat));
    exp = exp_q.pop_front();
    if (resp_lat != 0) check({tag, " resp {err,rdata}"}, got, exp);
    check({tag, " we latency"}, 33'(we_lat), 33'(v.exp_we_lat));
    if (v.exp_we_lat != 0) begin
      check({tag, " we index"}, {1'b0, we_idx}, {1'b0, v.exp_we_idx});
      check({tag, " we data"}, {1'b0, we_data}, {1'b0, v.exp_we_data});
    end
  endtask

  initial begin
    int   n;
    vec_t rv;
    logic [1:0]  rsz;
    logic [1:0]  roff;
    int          rw;
    logic        rsgn;

    mem[0] = 32'hA00000AA; mem[1] = 32'h10000011; mem[2] = 32'h20000022;
    for (int i = 3; i < 16; i++) mem[i] = 32'h0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {32'h0, req_ready}, 33'd1);
    check("reset resp_valid", {32'h0, resp_valid}, 33'd0);
    check("reset resp_err", {32'h0, resp_err}, 33'd0);
    check("reset resp_rdata", {1'b0, resp_rdata}, 33'd0);
    check("reset mem_we", {32'h0, mem_we}, 33'd0);
    check("reset mem_wdata", {1'b0, mem_wdata}, 33'd0);
    check("reset mem_read_addr", {1'b0, mem_read_addr}, 33'd0);
    check("reset mem_write_addr", {1'b0, mem_write_addr}, 33'd0);
    rst_n = 1'b1;

    //                wr   sz     sgn addr    wdata         err rdata         lat weLat idx  weData
    vecs[0]  = mk(1'b0, 2'b00, 1'b1, 32'd0,  32'h0,        1'b0, 32'hFFFFFFAA, 2, 0, 0, 0);
    vecs[1]  = mk(1'b0, 2'b00, 1'b0, 32'd0,  32'h0,        1'b0, 32'h000000AA, 2, 0, 0, 0);
    vecs[2]  = mk(1'b0, 2'b01, 1'b1, 32'd6,  32'h0,        1'b0, 32'h00001000, 2, 0, 0, 0);
    vecs[3]  = mk(1'b0, 2'b10, 1'b0, 32'd4,  32'h0,        1'b0, 32'h10000011, 2, 0, 0, 0);
    vecs[4]  = mk(1'b0, 2'b01, 1'b0, 32'd2,  32'h0,        1'b0, 32'h0000A000, 2, 0, 0, 0);
    vecs[5]  = mk(1'b0, 2'b01, 1'b1, 32'd2,  32'h0,        1'b0, 32'hFFFFA000, 2, 0, 0, 0);
    vecs[6]  = mk(1'b1, 2'b00, 1'b0, 32'd9,  32'hFFFFFF55, 1'b0, 32'h0,        3, 2, 2, 32'h20005522);
    vecs[7]  = mk(1'b0, 2'b00, 1'b1, 32'd9,  32'h0,        1'b0, 32'h00000055, 2, 0, 0, 0);
    vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'd12, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1, 3, 32'hDEADBEEF);
    vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 0, 0);
    vecs[10] = mk(1'b1, 2'b01, 1'b0, 32'd6,  32'h1234BEEF, 1'b0, 32'h0,        3, 2, 1, 32'hBEEF0011);
    vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'd4,  32'h0,        1'b0, 32'hBEEF0011, 2, 0, 0, 0);
    vecs[12] = mk(1'b0, 2'b10, 1'b0, 32'd2,  32'h0,        1'b1, 32'h0,        1, 0, 0, 0);
    vecs[13] = mk(1'b1, 2'b01, 1'b0, 32'd5,  32'hFFFF,     1'b1, 32'h0,        1, 0, 0, 0);
    vecs[14] = mk(1'b0, 2'b11, 1'b0, 32'd0,  32'h0,        1'b1, 32'h0,        1, 0, 0, 0);
    vecs[15] = mk(1'b1, 2'b11, 1'b0, 32'd8,  32'h77,       1'b1, 32'h0,        1, 0, 0, 0);
    n = 16;
    for (int i = 0; i < n; i++) run_req(vecs[i], $sformatf("vec%0d", i));
    check("word2 after sb", {1'b0, mem[2]}, {1'b0, 32'h20005522});
    check("word1 after sh", {1'b0, mem[1]}, {1'b0, 32'hBEEF0011});

    // random aligned loads against the bench's own reference extractor
    for (int i = 0; i < 20; i++) begin
      rw   = $urandom_range(0, 3);
      rsz  = 2'($urandom_range(0, 2));
      rsgn = 1'($urandom_range(0, 1));
      roff = 2'($urandom_range(0, 3));
      if (rsz == 2'b01) roff[0] = 1'b0;
      if (rsz == 2'b10) roff = 2'b00;
      rv = mk(1'b0, rsz, rsgn, 32'(rw * 4) | 32'(roff), 32'h0, 1'b0,
              ref_load(mem[rw], rsz, roff, rsgn), 2, 0, 0, 0);
      run_req(rv, $sformatf("rnd%0d", i));
    end

    // reset asserted during the WRITE cycle of a byte store
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd1; req_wdata = 32'h33; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst test we in WRITE", {32'h0, mem_we}, 33'd1);
    rst_n = 1'b0;
    #1;
    check("rst test we dropped", {32'h0, mem_we}, 33'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst test ready", {32'h0, req_ready}, 33'd1);
    begin
      int resp_seen;
      resp_seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (resp_valid || mem_we) resp_seen++;
      end
      check("rst test no resp/we", 33'(resp_seen), 33'd0);
    end
    check("rst test word0 unchanged", {1'b0, mem[0]}, {1'b0, 32'hA00000AA});
    check("scoreboard drained", 33'(exp_q.size()), 33'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
